// File: rtl/net_l2req_arb_if.sv
// Handshake bundle between the four L2 requesters, the arbiter and the
// directory side. Payloads are DATA_W-bit request words.
interface net_l2req_arb_if #(
  parameter int DATA_W = 32
);
  typedef logic [DATA_W-1:0] I_l2todr_req_type;

  // Requester side: index 0 = L2I, 1 = L2I TLB, 2 = L2D, 3 = L2D TLB
  logic [3:0]                   req_valid;
  logic [3:0]                   req_retry;
  logic [3:0][DATA_W-1:0]       req_data;

  // Directory side
  logic                         out_valid;
  logic                         out_retry;
  I_l2todr_req_type             out_req;
  logic [1:0]                   out_src;

  // Arbiter view
  modport master (
    input  req_valid, req_data, out_retry,
    output req_retry, out_valid, out_req, out_src
  );

  // Environment view (requesters + directory)
  modport slave (
    output req_valid, req_data, out_retry,
    input  req_retry, out_valid, out_req, out_src
  );
endinterface

// File: rtl/net_l2req_arb.sv
// net_l2req_arb: 4-way arbiter from the L2 request sources to the directory,
// with a single registered output slot (1-cycle latency, full throughput).
// Optional feature: define NET_L2REQ_ARB_TLBPRIO_EN to give TLB requesters
// (1, 3) priority over data requesters (0, 2), with a fairness counter that
// forces a data grant after FAIR_LIMIT TLB grants made while data waited.
module net_l2req_arb #(
  parameter int FAIR_LIMIT = 4,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  net_l2req_arb_if.master       bus
);

  typedef logic [DATA_W-1:0] req_t;

  // Range check on the fairness limit, evaluated at elaboration.
  if (FAIR_LIMIT < 1 || FAIR_LIMIT > 15) begin : g_bad_limit
    $error("net_l2req_arb: FAIR_LIMIT out of range 1..15");
  end

  logic [1:0] ptr_q, ptr_d;
  logic       out_valid_q, out_valid_d;
  req_t       out_req_q, out_req_d;
  logic [1:0] out_src_q, out_src_d;
  logic       can_load;
  logic       grant;
  logic [1:0] win;
  logic [2:0] pick;      // {found, index}
  logic [3:0] req_retry;

`ifdef NET_L2REQ_ARB_TLBPRIO_EN
  logic [3:0] fair_cnt_q, fair_cnt_d;
  logic [2:0] tlb_pick;
  logic [2:0] data_pick;
  logic       data_waiting;

  // Round-robin inside one class {lo = {0,cls}, hi = {1,cls}}. The shared
  // pointer's upper bit says which half was granted last, so the other
  // half of the class is preferred when both members are valid.
  function automatic logic [2:0] class_pick(input logic [3:0] mask,
                                            input logic       cls,
                                            input logic       last_hi);
    logic lo;
    logic hi;
    lo = mask[{1'b0, cls}];
    hi = mask[{1'b1, cls}];
    if (lo && (!hi || last_hi)) return {1'b1, 1'b0, cls};
    else if (hi)                return {1'b1, 1'b1, cls};
    else                        return 3'b000;
  endfunction
`else
  // First set bit of mask scanning last+1, last+2, last+3, last (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                         input logic [1:0] last);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (mask[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction
`endif

  // Winner selection, retry generation and next-state for the output slot.
  always_comb begin
    can_load    = !out_valid_q || !bus.out_retry;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_req_d   = out_req_q;
    out_src_d   = out_src_q;
    req_retry   = 4'b1111;

`ifdef NET_L2REQ_ARB_TLBPRIO_EN
    fair_cnt_d   = fair_cnt_q;
    data_waiting = bus.req_valid[0] || bus.req_valid[2];
    tlb_pick     = class_pick(bus.req_valid, 1'b1, ptr_q[1]);
    data_pick    = class_pick(bus.req_valid, 1'b0, ptr_q[1]);
    if (fair_cnt_q == 4'(FAIR_LIMIT) && data_pick[2]) pick = data_pick;
    else if (tlb_pick[2])                              pick = tlb_pick;
    else                                               pick = data_pick;
`else
    pick = rr_pick(bus.req_valid, ptr_q);
`endif

    // No grants while held in reset: retry stays all ones.
    grant = reset && can_load && pick[2];
    win   = pick[1:0];

    if (grant) begin
      req_retry[win] = 1'b0;
      out_req_d      = bus.req_data[win];
      out_src_d      = win;
      out_valid_d    = 1'b1;
      ptr_d          = win;
`ifdef NET_L2REQ_ARB_TLBPRIO_EN
      if (!win[0])           fair_cnt_d = 4'd0;
      else if (data_waiting) fair_cnt_d = fair_cnt_q + 4'd1;
`endif
    end else if (can_load) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any held request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= 2'd3;
      out_valid_q <= 1'b0;
      out_req_q   <= '0;
      out_src_q   <= 2'd0;
`ifdef NET_L2REQ_ARB_TLBPRIO_EN
      fair_cnt_q  <= 4'd0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_req_q   <= out_req_d;
      out_src_q   <= out_src_d;
`ifdef NET_L2REQ_ARB_TLBPRIO_EN
      fair_cnt_q  <= fair_cnt_d;
`endif
    end
  end

  assign bus.req_retry = req_retry;
  assign bus.out_valid = out_valid_q;
  assign bus.out_req   = out_req_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_net_l2req_arb.sv
// Directed, table-driven bench for net_l2req_arb (both macro settings).
module tb_net_l2req_arb;

  logic clk;
  logic reset;
  logic [3:0][31:0] dat;

  int n_tests = 0;
  int n_fail  = 0;

  net_l2req_arb_if #(.DATA_W(32)) bus ();

  net_l2req_arb #(.FAIR_LIMIT(4), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.req_data = dat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] valid;
    logic       oretry;
    logic [3:0] exp_retry;
    logic       exp_ov;
    logic [1:0] exp_src;
  } vec_t;

  vec_t vecs[$];
  int   exp_order[10];

  task automatic add(input logic [3:0] v, input logic r, input logic [3:0] er,
                     input logic eov, input logic [1:0] es);
    vec_t t;
    t.valid = v; t.oretry = r; t.exp_retry = er; t.exp_ov = eov; t.exp_src = es;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dat[i] = 32'hC0DE_0000 | 32'(i);

`ifdef NET_L2REQ_ARB_TLBPRIO_EN
    add(4'b1111, 1'b0, 4'b1101, 1'b1, 2'd1);
    add(4'b1111, 1'b0, 4'b0111, 1'b1, 2'd3);
    add(4'b1111, 1'b0, 4'b1101, 1'b1, 2'd1);
    add(4'b1111, 1'b0, 4'b0111, 1'b1, 2'd3);
    add(4'b1111, 1'b0, 4'b1110, 1'b1, 2'd0);
    add(4'b0000, 1'b0, 4'b1111, 1'b0, 2'd0);
    exp_order = '{1, 3, 1, 3, 2, 1, 3, 1, 3, 2};
`else
    add(4'b1111, 1'b0, 4'b1110, 1'b1, 2'd0);
    add(4'b1111, 1'b0, 4'b1101, 1'b1, 2'd1);
    add(4'b1111, 1'b0, 4'b1011, 1'b1, 2'd2);
    add(4'b1111, 1'b0, 4'b0111, 1'b1, 2'd3);
    add(4'b1111, 1'b0, 4'b1110, 1'b1, 2'd0);
    add(4'b0000, 1'b0, 4'b1111, 1'b0, 2'd0);
    add(4'b0100, 1'b0, 4'b1011, 1'b1, 2'd2);
    for (int k = 0; k < 5; k++) add(4'b1111, 1'b1, 4'b1111, 1'b1, 2'd2);
    add(4'b1111, 1'b0, 4'b0111, 1'b1, 2'd3);
    add(4'b0001, 1'b0, 4'b1110, 1'b1, 2'd0);
    add(4'b1010, 1'b0, 4'b1101, 1'b1, 2'd1);
    add(4'b1010, 1'b0, 4'b0111, 1'b1, 2'd3);
    add(4'b0000, 1'b1, 4'b1111, 1'b1, 2'd3);
    add(4'b0000, 1'b0, 4'b1111, 1'b0, 2'd3);
    exp_order = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 1};
`endif

    // Reset state, with every requester asking
    reset         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.out_retry = 1'b0;
    #12;
    check("rst_retry",  32'(bus.req_retry), 32'hF);
    check("rst_ovalid", 32'(bus.out_valid), 32'h0);
    check("rst_src",    32'(bus.out_src),   32'h0);
    check("rst_req",    bus.out_req,        32'h0);
    reset = 1'b1;

    // Table: inputs between edges, retry checked before the edge,
    // registered outputs checked just after it
    for (int i = 0; i < vecs.size(); i++) begin
      bus.req_valid = vecs[i].valid;
      bus.out_retry = vecs[i].oretry;
      #1;
      check($sformatf("vec%0d_retry", i), 32'(bus.req_retry), 32'(vecs[i].exp_retry));
      @(posedge clk); #1;
      check($sformatf("vec%0d_ovalid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d_src", i), 32'(bus.out_src), 32'(vecs[i].exp_src));
      check($sformatf("vec%0d_req", i), bus.out_req, dat[vecs[i].exp_src]);
    end

    // Single requester 2 streaming three A5 requests back to back
    dat[2]        = 32'hA5A5_A5A5;
    bus.req_valid = 4'b0100;
    bus.out_retry = 1'b0;
    #1;
    check("r2_pre_ovalid", 32'(bus.out_valid), 32'h0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("r2_c%0d_retry", c), 32'(bus.req_retry), 32'hB);
      @(posedge clk); #1;
      check($sformatf("r2_c%0d_ovalid", c), 32'(bus.out_valid), 32'h1);
      check($sformatf("r2_c%0d_src", c), 32'(bus.out_src), 32'h2);
      check($sformatf("r2_c%0d_req", c), bus.out_req, 32'hA5A5_A5A5);
    end
    bus.req_valid = 4'b0000;
    @(posedge clk); #1;
    check("r2_drain_ovalid", 32'(bus.out_valid), 32'h0);
    dat[2] = 32'hC0DE_0002;

    // Asynchronous reset while a request is stalled in the output slot
    bus.req_valid = 4'b0001;
    @(posedge clk); #1;
    check("ar_load_ovalid", 32'(bus.out_valid), 32'h1);
    bus.out_retry = 1'b1;
    bus.req_valid = 4'b1111;
    #2;
    reset = 1'b0;
    #1;
    check("ar_ovalid", 32'(bus.out_valid), 32'h0);
    check("ar_src",    32'(bus.out_src),   32'h0);
    check("ar_req",    bus.out_req,        32'h0);
    check("ar_retry",  32'(bus.req_retry), 32'hF);
    @(posedge clk); #1;
    reset         = 1'b1;
    bus.out_retry = 1'b0;
    bus.req_valid = 4'b0101;
    #1;
    check("ar_first_retry", 32'(bus.req_retry), 32'hE);
    @(posedge clk); #1;
    check("ar_first_src", 32'(bus.out_src), 32'h0);

    // Grant order with requesters 1, 2, 3 permanently valid
    reset = 1'b0;
    #1;
    reset         = 1'b1;
    bus.req_valid = 4'b1110;
    bus.out_retry = 1'b0;
    for (int g = 0; g < 10; g++) begin
      #1;
      check($sformatf("ord%0d_retry", g), 32'(bus.req_retry),
            32'(~(4'b0001 << exp_order[g]) & 4'hF));
      @(posedge clk); #1;
      check($sformatf("ord%0d_src", g), 32'(bus.out_src), 32'(exp_order[g]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/net_l2req_arb.md
NET_L2REQ_ARB -- requirements
Module: net_l2req_arb

Interface
REQ-001 The block SHALL have parameter FAIR_LIMIT, default 4, range 1..15: the number of consecutive TLB grants allowed while a data requester waits. It is used only when NET_L2REQ_ARB_TLBPRIO_EN is defined.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-004 The block SHALL have port req_valid, input, 4 bits: per-requester valid. Index 0 = L2I, 1 = L2I TLB, 2 = L2D, 3 = L2D TLB.
REQ-005 The block SHALL have port req_retry, output, 4 bits: per-requester retry (1 = not accepted this cycle).
REQ-006 The block SHALL have port req_data, input, 4 x I_l2todr_req_type: per-requester request payload.
REQ-007 The block SHALL have port out_valid, output, 1 bit: directory-side request valid.
REQ-008 The block SHALL have port out_retry, input, 1 bit: directory-side retry.
REQ-009 The block SHALL have port out_req, output, I_l2todr_req_type: directory-side payload.
REQ-010 The block SHALL have port out_src, output, 2 bits: index of the requester that owns out_req.

Function
REQ-011 A transfer on any channel SHALL occur exactly in a cycle where valid=1 and retry=0.
REQ-012 The block SHALL hold one request in an output register whose occupancy is out_valid.
REQ-013 The block SHALL compute can_load = !out_valid | !out_retry.
REQ-014 The winner SHALL be the first valid requester scanning ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr is a 2-bit last-grant pointer.
REQ-015 req_retry[i] SHALL be 0 only when can_load=1, req_valid[i]=1 and i is the winner; otherwise req_retry[i] SHALL be 1, including when req_valid[i]=0.
REQ-016 At most one req_retry bit SHALL be 0 in any cycle.
REQ-017 On a grant to winner w, at the next edge the block SHALL load out_req<=req_data[w], out_src<=w, out_valid<=1 and ptr<=w.
REQ-018 If can_load=1 and no requester is valid, the block SHALL clear out_valid at the next edge and leave out_req, out_src and ptr unchanged.
REQ-019 While out_valid=1 and out_retry=1, out_req and out_src SHALL remain stable and no requester SHALL be granted.
REQ-020 A drain and a load in the same cycle SHALL both take effect, giving a sustained throughput of 1 request per cycle.
REQ-021 Latency from input accept to out_valid SHALL be exactly 1 cycle.
REQ-022 req_retry MAY combinationally depend on out_retry. There SHALL be no combinational path from req_valid or req_data to out_valid, out_req or out_src.
REQ-023 A requester that is refused SHALL hold valid and data; the block does not check this.

Reset
REQ-024 While reset=0 the block SHALL force, asynchronously: out_valid=0, out_src=0, ptr=3 (so requester 0 has first priority), fair_cnt=0, and out_req to all zeros.
REQ-025 req_retry SHALL be 4'b1111 during reset.
REQ-026 A request held in the output register when reset asserts SHALL be discarded; no partial transfer is reported.
REQ-027 The first grant SHALL be possible in the first cycle with reset=1.

Configuration
REQ-028 With macro NET_L2REQ_ARB_TLBPRIO_EN defined, TLB requesters (1 and 3) SHALL beat data requesters (0 and 2). Round-robin SHALL apply within each class using the shared ptr.
REQ-029 With the macro defined, a 4-bit fair_cnt SHALL increment on each TLB grant made while req_valid[0] or req_valid[2] is 1, and SHALL clear on any data grant.
REQ-030 With the macro defined, when fair_cnt==FAIR_LIMIT the next grant SHALL go to the round-robin data winner if one is valid.
REQ-031 With the macro undefined, fair_cnt SHALL not exist and arbitration SHALL be plain 4-way round-robin per REQ-014.

Verification
REQ-032 Reset release, req_valid=4'b1111 every cycle, out_retry=0 -> out_src sequence 0,1,2,3,0; req_retry shows one zero bit per cycle.
REQ-033 One valid request, then out_retry=1 held for 5 cycles -> out_req and out_src stable for all 5 cycles, req_retry=4'b1111; on the first cycle with out_retry=0 the next grant occurs in that same cycle.
REQ-034 Only requester 2 valid, with data 0xA5.. pattern, for 3 cycles, out_retry=0 -> out_valid=1 for 3 consecutive cycles starting 1 cycle after the first accept, and out_src=2 throughout.
REQ-035 reset driven to 0 mid-cycle while out_valid=1 and out_retry=1 -> out_valid=0 immediately (no clock edge needed); after release, requester 0 wins first.
REQ-036 With NET_L2REQ_ARB_TLBPRIO_EN, FAIR_LIMIT=4, requesters 1, 2 and 3 always valid -> grant order 1,3,1,3,2,1,3,1,3,2.
REQ-037 Without the macro, using the stimulus of REQ-036 -> grant order 1,2,3,1,2,3.
